// File: rtl/kp_pkg.sv
// Shared definitions for the keypad scan interface: responder states,
// matrix geometry and the key codes used by the mode logic.
package kp_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  localparam logic [KEY_W-1:0] KEY_RESET = 4'd10;
  localparam logic [KEY_W-1:0] KEY_LAP   = 4'd11;
  localparam logic [KEY_W-1:0] KEY_START = 4'd12;
  localparam logic [KEY_W-1:0] KEY_STOP  = 4'd13;
  localparam logic [KEY_W-1:0] KEY_OP_A  = 4'd14;
  localparam logic [KEY_W-1:0] KEY_OP_B  = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    B_PRESS,
    HELD,
    B_REL,
    GAP
  } state_t;

endpackage

// File: rtl/kp_column_drive.sv
// Maps one modelled switch (key code + contact state) onto the active-low
// column sense lines, given the scanner's live active-low row drive.
module kp_column_drive
  import kp_pkg::*;
(
  input  logic             contact,
  input  logic [KEY_W-1:0] key,
  input  logic [ROWS-1:0]  line,
  output logic [COLS-1:0]  collummn
);

  // NOTE: every output of an always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    collummn = '1;
    if (contact && !line[key[3:2]]) begin
      collummn[key[1:0]] = 1'b0;
    end
  end

endmodule

// File: rtl/keypad_matrix_responder.sv
// Switch-side keypad model: plays one scripted press (bounce, hold, bounce,
// open gap) per request and answers the scanner's row drive on COLLUMMN.
module keypad_matrix_responder
  import kp_pkg::*;
#(
  parameter int BOUNCE_DIV = 4,
  parameter int GAP_CYCLES = 64,
  parameter int HOLD_W     = 16,
  parameter int BOUNCE_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_W-1:0]    req_key,
  input  logic [HOLD_W-1:0]   req_hold,
  input  logic [BOUNCE_W-1:0] req_bounce,
  input  logic                cancel,
  input  logic [ROWS-1:0]     LINE,
  output logic [COLS-1:0]     COLLUMMN,
  output logic                contact,
  output logic                busy,
  output logic                done
);

  localparam int PH_IDX = $clog2(BOUNCE_DIV);
  localparam int PH_W   = PH_IDX + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  state_t              state, state_next;
  logic [KEY_W-1:0]    key_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [BOUNCE_W-1:0] bounce_q;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [BOUNCE_W-1:0] bounce_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [PH_W-1:0]     phase;
  logic [HOLD_W-1:0]   hold_src;
  logic                accept;

  assign accept    = req_valid && req_ready;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == GAP) && (gap_cnt == '0);

  // HELD is entered straight from IDLE when bounce is zero, before hold_q is written.
  assign hold_src = (state == IDLE) ? req_hold : hold_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = (req_bounce == '0) ? HELD : B_PRESS;
        end
      end
      B_PRESS: begin
        if (cancel) begin
          state_next = GAP;
        end else if (bounce_cnt == '0) begin
          state_next = HELD;
        end
      end
      HELD: begin
        if (cancel) begin
          state_next = GAP;
        end else if (hold_cnt == '0) begin
          state_next = (bounce_q == '0) ? GAP : B_REL;
        end
      end
      B_REL: begin
        if (cancel || bounce_cnt == '0) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bounce phase starts at 0 on entry: first press cycle closed, first release cycle open.
  always_comb begin
    contact = 1'b0;
    case (state)
      B_PRESS: contact = ~phase[PH_IDX];
      HELD:    contact = 1'b1;
      B_REL:   contact = phase[PH_IDX];
      default: contact = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      key_q      <= '0;
      hold_q     <= '0;
      bounce_q   <= '0;
      hold_cnt   <= '0;
      bounce_cnt <= '0;
      gap_cnt    <= '0;
      phase      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        key_q    <= req_key;
        hold_q   <= req_hold;
        bounce_q <= req_bounce;
      end
      if (state_next != state) begin
        phase <= '0;
        case (state_next)
          B_PRESS: bounce_cnt <= req_bounce - 1'b1;
          B_REL:   bounce_cnt <= bounce_q - 1'b1;
          HELD:    hold_cnt   <= (hold_src == '0) ? '0 : hold_src - 1'b1;
          GAP:     gap_cnt    <= GAP_LOAD;
          default: ;
        endcase
      end else begin
        phase <= phase + 1'b1;
        if ((state == B_PRESS || state == B_REL) && bounce_cnt != '0) begin
          bounce_cnt <= bounce_cnt - 1'b1;
        end
        if (state == HELD && hold_cnt != '0) begin
          hold_cnt <= hold_cnt - 1'b1;
        end
        if (state == GAP && gap_cnt != '0) begin
          gap_cnt <= gap_cnt - 1'b1;
        end
      end
    end
  end

  kp_column_drive u_column_drive (
    .contact  (contact),
    .key      (key_q),
    .line     (LINE),
    .collummn (COLLUMMN)
  );

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Directed bench: each stimulus cycle is queued with its expected outputs,
// then replayed one clock at a time and compared at the falling edge.
module tb_keypad_matrix_responder;
  import kp_pkg::*;

  localparam int DIV = 4;
  localparam int GAP = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_key;
  logic [15:0] req_hold;
  logic [7:0]  req_bounce;
  logic        cancel;
  logic [3:0]  LINE;
  logic [3:0]  COLLUMMN;
  logic        contact;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  keypad_matrix_responder #(
    .BOUNCE_DIV (DIV),
    .GAP_CYCLES (GAP),
    .HOLD_W     (16),
    .BOUNCE_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_key    (req_key),
    .req_hold   (req_hold),
    .req_bounce (req_bounce),
    .cancel     (cancel),
    .LINE       (LINE),
    .COLLUMMN   (COLLUMMN),
    .contact    (contact),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  key;
    logic [15:0] hold;
    logic [7:0]  bounce;
    logic        cnl;
    logic [3:0]  line;
    logic        c;
    logic        d;
    logic        b;
    logic        r;
  } step_t;

  step_t       exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          step  = 0;
  int          line_idx = 0;
  logic [3:0]  line_pat[6] = '{4'b1011, 4'b1101, 4'b1110, 4'b0111, 4'b0000, 4'b1111};

  function automatic logic [3:0] col_model(logic c, logic [3:0] key, logic [3:0] line);
    logic [3:0] r;
    r = 4'b1111;
    if (c && line[key[3:2]] == 1'b0) r[key[1:0]] = 1'b0;
    return r;
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, expv);
    end
  endtask

  task automatic push(logic valid, logic [3:0] key, logic [15:0] hold, logic [7:0] bounce,
                      logic cnl, int line_fix, logic c, logic d, logic b, logic r);
    step_t e;
    e.valid  = valid;
    e.key    = key;
    e.hold   = hold;
    e.bounce = bounce;
    e.cnl    = cnl;
    e.line   = (line_fix < 0) ? line_pat[line_idx % 6] : 4'(line_fix);
    e.c      = c;
    e.d      = d;
    e.b      = b;
    e.r      = r;
    line_idx++;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(int n);
    for (int i = 0; i < n; i++) push(1'b0, 4'd0, 16'd0, 8'd0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // One full press as seen from outside: accept cycle, bounce, hold, bounce, gap.
  task automatic push_press(logic [3:0] key, logic [15:0] hold, logic [7:0] bounce,
                            int cancel_at, logic keep, int line_fix);
    int  h;
    bit  cut;
    h   = (hold == 16'd0) ? 1 : int'(hold);
    cut = 1'b0;
    push(1'b1, key, hold, bounce, 1'b0, line_fix, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int p = 0; p < int'(bounce); p++)
      push(keep, key, hold, bounce, 1'b0, line_fix, ((p / DIV) % 2) == 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < h; i++) begin
      push(keep, key, hold, bounce, i == cancel_at, line_fix, 1'b1, 1'b0, 1'b1, 1'b0);
      if (i == cancel_at) begin
        cut = 1'b1;
        break;
      end
    end
    if (!cut) begin
      for (int p = 0; p < int'(bounce); p++)
        push(keep, key, hold, bounce, 1'b0, line_fix, ((p / DIV) % 2) == 1, 1'b0, 1'b1, 1'b0);
    end
    for (int g = 0; g < GAP; g++)
      push(keep, key, hold, bounce, 1'b0, line_fix, 1'b0, g == GAP - 1, 1'b1, 1'b0);
  endtask

  // Called just after a rising edge; leaves just after a rising edge.
  task automatic run(int n);
    step_t e;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e          = exp_q.pop_front();
      req_valid  = e.valid;
      req_key    = e.key;
      req_hold   = e.hold;
      req_bounce = e.bounce;
      cancel     = e.cnl;
      LINE       = e.line;
      @(negedge clk);
      check("contact",  16'(contact),  16'(e.c));
      check("done",     16'(done),     16'(e.d));
      check("busy",     16'(busy),     16'(e.b));
      check("ready",    16'(req_ready), 16'(e.r));
      check("collummn", 16'(COLLUMMN), 16'(col_model(e.c, e.key, e.line)));
      step++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    cancel    = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_key    = 4'd0;
    req_hold   = 16'd0;
    req_bounce = 8'd0;
    cancel     = 1'b0;
    LINE       = 4'b0000;
    #1;
    check("rst_contact",  16'(contact),   16'd0);
    check("rst_done",     16'(done),      16'd0);
    check("rst_busy",     16'(busy),      16'd0);
    check("rst_ready",    16'(req_ready), 16'd1);
    check("rst_collummn", 16'(COLLUMMN),  16'hF);
    #21 rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean press, bounced press, cancelled press.
    push_press(4'd6, 16'd10, 8'd0, -1, 1'b0, -1);
    push_idle(2);
    push_press(KEY_RESET & 4'd0, 16'd5, 8'd16, -1, 1'b0, -1);
    push_idle(2);
    push_press(KEY_OP_B, 16'd1000, 8'd0, 19, 1'b0, -1);
    push_idle(2);
    // req_valid held high across two back-to-back presses.
    push_press(KEY_STOP, 16'd3, 8'd0, -1, 1'b1, -1);
    push_press(KEY_OP_A, 16'd4, 8'd2, -1, 1'b0, -1);
    push_idle(2);
    // hold=0 acts as one cycle; all rows driven low.
    push_press(4'd9, 16'd0, 8'd0, -1, 1'b0, 0);
    push_idle(2);
    run(exp_q.size());

    // Asynchronous reset in the middle of HELD, off the clock edge.
    push_press(4'd5, 16'd1000, 8'd0, -1, 1'b0, 4'b1101);
    run(31);
    exp_q.delete();
    LINE = 4'b1101;
    #3 rst = 1'b1;
    #1;
    check("arst_collummn", 16'(COLLUMMN), 16'hF);
    check("arst_contact",  16'(contact),  16'd0);
    check("arst_done",     16'(done),     16'd0);
    check("arst_ready",    16'(req_ready), 16'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    push_idle(70);
    run(exp_q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
